fu_alu_pipe: RTL and testbench

//  Parametrised, elastic multi-stage integer ALU functional unit for the R10K core.

---
 rtl/fu_alu_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_fu_alu_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: elastic multi-stage integer ALU functional unit.
// Executes the Alpha INTA/INTL/INTS operate groups and LDA, then carries the
// result through STAGES register stages towards the CDB. Stages are squashed
// individually on branch recovery and resolved branch tags are cleared in
// flight.
// Optional feature: define FU_ALU_PIPE_SQUASH_CNT_EN to add squash_cnt_o, a
// saturating count of in-flight ops killed by branch recovery.
module fu_alu_pipe #(
  parameter int XLEN      = 64,
  parameter int STAGES    = 2,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [XLEN-1:0]      opa_i,
  input  logic [XLEN-1:0]      opb_i,
  input  logic [31:0]          inst_i,
  input  logic [PRF_IDX_W-1:0] dest_tag_i,
  input  logic [ROB_IDX_W:0]   rob_idx_i,
  input  logic [BR_MASK_W-1:0] br_mask_i,
  input  logic                 rob_br_recovery_i,
  input  logic                 rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
  input  logic                 stall_i,
  output logic                 ready_o,
  output logic                 done_pre_o,
  output logic                 done_o,
  output logic [XLEN-1:0]      result_o,
  output logic [PRF_IDX_W-1:0] dest_tag_o,
  output logic [ROB_IDX_W:0]   rob_idx_o,
  output logic [BR_MASK_W-1:0] br_mask_o
`ifdef FU_ALU_PIPE_SQUASH_CNT_EN
  ,
  output logic [15:0]          squash_cnt_o
`endif
);

  localparam int SHW = $clog2(XLEN);

  // Filler for undefined encodings; truncated when XLEN is not a multiple of 32.
  localparam int                 BEEF_REP  = (XLEN + 31) / 32;
  localparam logic [32*BEEF_REP-1:0] BEEF_WIDE = {BEEF_REP{32'hdeadbeef}};
  localparam logic [XLEN-1:0]    BEEF      = BEEF_WIDE[XLEN-1:0];

  // Opcodes (inst[31:26]) and function codes (inst[11:5]).
  localparam logic [5:0] OPC_LDA  = 6'h08;
  localparam logic [5:0] OPC_INTA = 6'h10;
  localparam logic [5:0] OPC_INTL = 6'h11;
  localparam logic [5:0] OPC_INTS = 6'h12;

  localparam logic [6:0] FN_ADDQ   = 7'h20;
  localparam logic [6:0] FN_SUBQ   = 7'h29;
  localparam logic [6:0] FN_CMPEQ  = 7'h2d;
  localparam logic [6:0] FN_CMPULT = 7'h1d;
  localparam logic [6:0] FN_CMPULE = 7'h3d;
  localparam logic [6:0] FN_CMPLT  = 7'h4d;
  localparam logic [6:0] FN_CMPLE  = 7'h6d;
  localparam logic [6:0] FN_AND    = 7'h00;
  localparam logic [6:0] FN_BIC    = 7'h08;
  localparam logic [6:0] FN_BIS    = 7'h20;
  localparam logic [6:0] FN_ORNOT  = 7'h28;
  localparam logic [6:0] FN_XOR    = 7'h40;
  localparam logic [6:0] FN_EQV    = 7'h48;
  localparam logic [6:0] FN_SRL    = 7'h34;
  localparam logic [6:0] FN_SLL    = 7'h39;
  localparam logic [6:0] FN_SRA    = 7'h3c;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      res;
    logic [PRF_IDX_W-1:0] tag;
    logic [ROB_IDX_W:0]   rob;
    logic [BR_MASK_W-1:0] mask;
  } stage_t;

  stage_t stg_q [STAGES];
  stage_t stg_d [STAGES];
  stage_t up    [STAGES];
  stage_t in_s;

  logic [5:0]           op_class;
  logic [6:0]           func;
  logic [XLEN-1:0]      opa, opb, alu_res;
  logic [SHW-1:0]       sh;
  logic [STAGES-1:0]    adv, kill, load;
  logic [BR_MASK_W-1:0] clr_mask;

  // Register-number fields are resolved upstream by rename; not needed here.
  logic unused_inst;
  assign unused_inst = ^inst_i[25:21];

  // Operand select and single-cycle compute ahead of stage 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    op_class = {inst_i[31:29], 3'b000};
    func     = inst_i[11:5];
    opa      = opa_i;
    opb      = opb_i;
    if (op_class == 6'h10 && inst_i[12]) opb = XLEN'(inst_i[20:13]);
    if (op_class == 6'h08 || op_class == 6'h20 || op_class == 6'h28)
      opa = XLEN'($signed(inst_i[15:0]));
    sh      = opb[SHW-1:0];
    alu_res = BEEF;
    case (inst_i[31:26])
      OPC_INTA: begin
        case (func)
          FN_ADDQ:   alu_res = opa + opb;
          FN_SUBQ:   alu_res = opa - opb;
          FN_CMPEQ:  alu_res = XLEN'(opa == opb);
          FN_CMPULT: alu_res = XLEN'(opa < opb);
          FN_CMPULE: alu_res = XLEN'(opa <= opb);
          FN_CMPLT:  alu_res = XLEN'($signed(opa) < $signed(opb));
          FN_CMPLE:  alu_res = XLEN'($signed(opa) <= $signed(opb));
          default:   alu_res = BEEF;
        endcase
      end
      OPC_INTL: begin
        case (func)
          FN_AND:   alu_res = opa & opb;
          FN_BIC:   alu_res = opa & ~opb;
          FN_BIS:   alu_res = opa | opb;
          FN_ORNOT: alu_res = opa | ~opb;
          FN_XOR:   alu_res = opa ^ opb;
          FN_EQV:   alu_res = ~(opa ^ opb);
          default:  alu_res = BEEF;
        endcase
      end
      OPC_INTS: begin
        case (func)
          FN_SRL:  alu_res = opa >> sh;
          FN_SLL:  alu_res = opa << sh;
          FN_SRA:  alu_res = $signed(opa) >>> sh;
          default: alu_res = BEEF;
        endcase
      end
      OPC_LDA: alu_res = opa + opb;
      default: alu_res = BEEF;
    endcase
  end

  // Advance chain (bubble collapse from the CDB end), per-stage squash and load enables.
  always_comb begin
    adv           = '0;
    adv[STAGES-1] = ~stall_i;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = ~stg_q[k+1].valid | adv[k+1];
    for (int k = 0; k < STAGES; k++) begin
      kill[k] = rob_br_recovery_i & stg_q[k].valid & (|(stg_q[k].mask & rob_br_tag_fix_i));
      load[k] = ~rob_br_recovery_i & (~stg_q[k].valid | adv[k]);
    end
  end

  assign ready_o = (~stg_q[0].valid | adv[0]) & ~rob_br_recovery_i;

  // Next state of every stage: squash, shift in from upstream, or hold; resolved tag bits cleared.
  always_comb begin
    clr_mask = (rob_br_pred_correct_i & ~rob_br_recovery_i) ? ~rob_br_tag_fix_i : '1;
    in_s     = '0;
    if (start_i && ready_o) begin
      in_s.valid = 1'b1;
      in_s.res   = alu_res;
      in_s.tag   = dest_tag_i;
      in_s.rob   = rob_idx_i;
      in_s.mask  = br_mask_i;
    end
    up[0] = in_s;
    for (int k = 1; k < STAGES; k++) up[k] = stg_q[k-1];
    for (int k = 0; k < STAGES; k++) begin
      // An empty upstream stage always carries an all-zero payload, so copying it clears this one.
      if (kill[k])      stg_d[k] = '0;
      else if (load[k]) stg_d[k] = up[k];
      else              stg_d[k] = stg_q[k];
      stg_d[k].mask = stg_d[k].mask & clr_mask;
    end
  end

  // Pipeline stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload is reset along with valid because an empty stage must read back as zero.
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses <= so every stage samples the pre-edge values of its neighbour.
      for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
    end
  end

  assign done_o     = stg_q[STAGES-1].valid;
  assign result_o   = stg_q[STAGES-1].res;
  assign dest_tag_o = stg_q[STAGES-1].tag;
  assign rob_idx_o  = stg_q[STAGES-1].rob;
  assign br_mask_o  = stg_q[STAGES-1].mask;

  generate
    if (STAGES == 1) begin : g_pre_single
      assign done_pre_o = start_i & ready_o;
    end else begin : g_pre_multi
      assign done_pre_o = stg_q[STAGES-2].valid & adv[STAGES-2] & ~rob_br_recovery_i;
    end
  endgenerate

`ifdef FU_ALU_PIPE_SQUASH_CNT_EN
  logic [15:0] squash_cnt_q, squash_cnt_d;
  logic [16:0] squash_sum;

  // Saturating sum of the stages killed this cycle.
  always_comb begin
    squash_sum = {1'b0, squash_cnt_q};
    for (int k = 0; k < STAGES; k++) squash_sum = squash_sum + 17'(kill[k]);
    squash_cnt_d = squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
  end

  // Squash counter register.
  always_ff @(posedge clk) begin
    if (rst) squash_cnt_q <= '0;
    else     squash_cnt_q <= squash_cnt_d;
  end

  assign squash_cnt_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Directed testbench for fu_alu_pipe (64-bit/2-stage instance plus a 32-bit instance).
module tb_fu_alu_pipe;

  localparam int XLEN = 64;
  localparam int STG  = 2;
  localparam int PRFW = 6;
  localparam int ROBW = 5;
  localparam int BRMW = 4;

  localparam logic [5:0] LDA  = 6'h08;
  localparam logic [5:0] INTA = 6'h10;
  localparam logic [5:0] INTL = 6'h11;
  localparam logic [5:0] INTS = 6'h12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start, start32;
  logic [63:0]     opa, opb;
  logic [31:0]     opa32, opb32;
  logic [31:0]     inst;
  logic [PRFW-1:0] tag_in;
  logic [ROBW:0]   rob_in;
  logic [BRMW-1:0] mask_in;
  logic            recovery, pred_ok, stall;
  logic [BRMW-1:0] tag_fix;

  logic            ready, done_pre, done;
  logic [63:0]     result;
  logic [PRFW-1:0] tag_out;
  logic [ROBW:0]   rob_out;
  logic [BRMW-1:0] mask_out;

  logic            ready32, done_pre32, done32;
  logic [31:0]     result32;
  logic [PRFW-1:0] tag_out32;
  logic [ROBW:0]   rob_out32;
  logic [BRMW-1:0] mask_out32;
`ifdef FU_ALU_PIPE_SQUASH_CNT_EN
  logic [15:0]     squash_cnt, squash_cnt32;
`endif

  fu_alu_pipe #(.XLEN(XLEN), .STAGES(STG), .PRF_IDX_W(PRFW), .ROB_IDX_W(ROBW), .BR_MASK_W(BRMW)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .opa_i(opa), .opb_i(opb), .inst_i(inst),
    .dest_tag_i(tag_in), .rob_idx_i(rob_in), .br_mask_i(mask_in),
    .rob_br_recovery_i(recovery), .rob_br_pred_correct_i(pred_ok), .rob_br_tag_fix_i(tag_fix),
    .stall_i(stall), .ready_o(ready), .done_pre_o(done_pre), .done_o(done), .result_o(result),
    .dest_tag_o(tag_out), .rob_idx_o(rob_out), .br_mask_o(mask_out)
`ifdef FU_ALU_PIPE_SQUASH_CNT_EN
    , .squash_cnt_o(squash_cnt)
`endif
  );

  fu_alu_pipe #(.XLEN(32), .STAGES(STG), .PRF_IDX_W(PRFW), .ROB_IDX_W(ROBW), .BR_MASK_W(BRMW)) u_dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .opa_i(opa32), .opb_i(opb32), .inst_i(inst),
    .dest_tag_i(tag_in), .rob_idx_i(rob_in), .br_mask_i(mask_in),
    .rob_br_recovery_i(recovery), .rob_br_pred_correct_i(pred_ok), .rob_br_tag_fix_i(tag_fix),
    .stall_i(stall), .ready_o(ready32), .done_pre_o(done_pre32), .done_o(done32), .result_o(result32),
    .dest_tag_o(tag_out32), .rob_idx_o(rob_out32), .br_mask_o(mask_out32)
`ifdef FU_ALU_PIPE_SQUASH_CNT_EN
    , .squash_cnt_o(squash_cnt32)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] op_r(input logic [5:0] opc, input logic [6:0] fn);
    return {opc, 5'd0, 5'd0, 3'd0, 1'b0, fn, 5'd0};
  endfunction

  function automatic logic [31:0] op_l(input logic [5:0] opc, input logic [6:0] fn, input logic [7:0] lit);
    return {opc, 5'd0, lit, 1'b1, fn, 5'd0};
  endfunction

  function automatic logic [31:0] op_m(input logic [5:0] opc, input logic [15:0] disp);
    return {opc, 5'd0, 5'd0, disp};
  endfunction

  task automatic issue(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                       input logic [PRFW-1:0] t, input logic [ROBW:0] r, input logic [BRMW-1:0] m);
    start = 1'b1; inst = i; opa = a; opb = b; tag_in = t; rob_in = r; mask_in = m;
  endtask

  task automatic idle();
    start = 1'b0; inst = '0; opa = '0; opb = '0; tag_in = '0; rob_in = '0; mask_in = '0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    vec_t v;
    v.inst = i; v.a = a; v.b = b; v.exp = e;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle(); start32 = 1'b0; opa32 = '0; opb32 = '0;
    stall = 1'b0; recovery = 1'b0; pred_ok = 1'b0; tag_fix = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset ready", ready, 1);
    check("reset done_pre", done_pre, 0);
    check("reset tag", tag_out, 0);
`ifdef FU_ALU_PIPE_SQUASH_CNT_EN
    check("reset squash_cnt", squash_cnt, 0);
`endif

    // Single ADDQ: latency 2, early wakeup one cycle before done.
    @(negedge clk); issue(op_r(INTA, 7'h20), 64'd5, 64'd7, 6'h2A, 6'h15, 4'h0); #1;
    check("t1 ready", ready, 1);
    check("t1 pre at issue", done_pre, 0);
    @(negedge clk); idle(); #1;
    check("t1 done_pre", done_pre, 1);
    check("t1 done early", done, 0);
    @(negedge clk); #1;
    check("t1 done", done, 1);
    check("t1 result", result, 64'd12);
    check("t1 tag", tag_out, 6'h2A);
    check("t1 rob", rob_out, 6'h15);
    @(negedge clk); #1;
    check("t1 done drop", done, 0);

    // Back-to-back operations, one result per cycle.
    add_vec(op_r(INTA, 7'h29), 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    add_vec(op_r(INTA, 7'h4d), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    add_vec(op_l(INTS, 7'h3c, 8'd4), 64'h8000_0000_0000_0000, 64'd0, 64'hF800_0000_0000_0000);
    add_vec(op_r(INTA, 7'h1d), 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    add_vec(op_r(INTA, 7'h3d), 64'd5, 64'd5, 64'd1);
    add_vec(op_r(INTA, 7'h2d), 64'd3, 64'd4, 64'd0);
    add_vec(op_r(INTA, 7'h6d), 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    add_vec(op_r(INTL, 7'h00), 64'hF0, 64'h3C, 64'h30);
    add_vec(op_r(INTL, 7'h08), 64'hF0, 64'h30, 64'hC0);
    add_vec(op_r(INTL, 7'h20), 64'hF0, 64'h0F, 64'hFF);
    add_vec(op_r(INTL, 7'h28), 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    add_vec(op_r(INTL, 7'h40), 64'hFF, 64'h0F, 64'hF0);
    add_vec(op_r(INTL, 7'h48), 64'h0, 64'hF, 64'hFFFF_FFFF_FFFF_FFF0);
    add_vec(op_l(INTS, 7'h39, 8'd63), 64'd1, 64'd0, 64'h8000_0000_0000_0000);
    add_vec(op_l(INTS, 7'h34, 8'd63), 64'h8000_0000_0000_0000, 64'd0, 64'd1);
    add_vec(op_r(INTA, 7'h20), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    add_vec(op_l(INTA, 7'h20, 8'd255), 64'd10, 64'd999, 64'h109);
    add_vec(op_r(INTA, 7'h7f), 64'd1, 64'd2, 64'hDEAD_BEEF_DEAD_BEEF);
    add_vec(op_m(LDA, 16'h0010), 64'h1234, 64'h20, 64'h30);
    add_vec(op_m(LDA, 16'hFFF0), 64'h0, 64'h100, 64'hF0);
    add_vec(op_r(INTS, 7'h3c), 64'hFFFF_FFFF_FFFF_FF00, 64'h44, 64'hFFFF_FFFF_FFFF_FFF0);
    add_vec(op_r(6'h29, 7'h00), 64'd1, 64'd2, 64'hDEAD_BEEF_DEAD_BEEF);
    for (int i = 0; i < vq.size() + 2; i++) begin
      @(negedge clk);
      if (i < vq.size()) issue(vq[i].inst, vq[i].a, vq[i].b, 6'(i), 6'(i + 1), 4'h0);
      else idle();
      #1;
      if (i >= 2) begin
        check($sformatf("vec%0d done", i - 2), done, 1);
        check($sformatf("vec%0d result", i - 2), result, vq[i-2].exp);
        check($sformatf("vec%0d tag", i - 2), tag_out, 6'(i - 2));
      end
    end
    @(negedge clk); #1;
    check("vec drain", done, 0);

    // Stall for 3 cycles with two ops in flight.
    @(negedge clk); issue(op_r(INTA, 7'h20), 64'd1, 64'd1, 6'd1, 6'd1, 4'h0);
    @(negedge clk); issue(op_r(INTL, 7'h40), 64'hF0, 64'h0F, 6'd2, 6'd2, 4'h0);
    @(negedge clk); idle(); stall = 1'b1; #1;
    check("t3 done", done, 1);
    check("t3 result", result, 64'd2);
    check("t3 ready full", ready, 0);
    check("t3 pre stalled", done_pre, 0);
    @(negedge clk); #1;
    check("t3 hold1 done", done, 1);
    check("t3 hold1 result", result, 64'd2);
    @(negedge clk); #1;
    check("t3 hold2 result", result, 64'd2);
    check("t3 hold2 tag", tag_out, 6'd1);
    @(negedge clk); stall = 1'b0; #1;
    check("t3 hold3 result", result, 64'd2);
    check("t3 release ready", ready, 1);
    @(negedge clk); #1;
    check("t3 second done", done, 1);
    check("t3 second result", result, 64'hFF);
    check("t3 second tag", tag_out, 6'd2);
    @(negedge clk); #1;
    check("t3 no dup", done, 0);

    // Recovery kills s1 (mask 0010) and freezes s0 (mask 0001).
    @(negedge clk); issue(op_r(INTA, 7'h20), 64'h11, 64'h0, 6'd3, 6'd3, 4'b0010);
    @(negedge clk); issue(op_r(INTA, 7'h20), 64'h22, 64'h0, 6'd4, 6'd4, 4'b0001);
    @(negedge clk); idle(); recovery = 1'b1; tag_fix = 4'b0010; #1;
    check("t4 ready", ready, 0);
    check("t4 pre", done_pre, 0);
    @(negedge clk); recovery = 1'b0; tag_fix = '0; #1;
    check("t4 killed done", done, 0);
    check("t4 killed result", result, 0);
    check("t4 killed tag", tag_out, 0);
    check("t4 killed mask", mask_out, 0);
    check("t4 pre survivor", done_pre, 1);
`ifdef FU_ALU_PIPE_SQUASH_CNT_EN
    check("t4 squash_cnt", squash_cnt, 1);
`endif
    @(negedge clk); #1;
    check("t4 survivor done", done, 1);
    check("t4 survivor result", result, 64'h22);
    check("t4 survivor tag", tag_out, 6'd4);
    check("t4 survivor mask", mask_out, 4'b0001);
    @(negedge clk); #1;
    check("t4 drain", done, 0);

    // Correct prediction clears the resolved bit in flight and on the incoming op.
    @(negedge clk); issue(op_r(INTA, 7'h20), 64'd1, 64'd2, 6'd5, 6'd5, 4'b0011);
    @(negedge clk); issue(op_r(INTA, 7'h20), 64'd3, 64'd4, 6'd6, 6'd6, 4'b0001);
    pred_ok = 1'b1; tag_fix = 4'b0001; #1;
    check("t5 ready", ready, 1);
    @(negedge clk); idle(); pred_ok = 1'b0; tag_fix = '0; #1;
    check("t5 first tag", tag_out, 6'd5);
    check("t5 first result", result, 64'd3);
    check("t5 first mask", mask_out, 4'b0010);
    @(negedge clk); #1;
    check("t5 second tag", tag_out, 6'd6);
    check("t5 second result", result, 64'd7);
    check("t5 second mask", mask_out, 4'b0000);
    @(negedge clk); #1;

    // Reset mid-flight.
    @(negedge clk); issue(op_r(INTA, 7'h20), 64'd1, 64'd1, 6'd7, 6'd3, 4'b0100);
    @(negedge clk); issue(op_r(INTA, 7'h20), 64'd2, 64'd2, 6'd8, 6'd4, 4'b0000);
    @(negedge clk); idle(); #1;
    check("t6 pre-reset done", done, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("t6 done", done, 0);
    check("t6 result", result, 0);
    check("t6 tag", tag_out, 0);
    check("t6 rob", rob_out, 0);
    check("t6 mask", mask_out, 0);
    check("t6 ready", ready, 1);
    check("t6 pre", done_pre, 0);
`ifdef FU_ALU_PIPE_SQUASH_CNT_EN
    check("t6 squash_cnt", squash_cnt, 0);
`endif
    @(negedge clk); #1;
    check("t6 no ghost", done, 0);

    // 32-bit instance: LDA with negative displacement, then an undefined op.
    @(negedge clk); start32 = 1'b1; inst = op_m(LDA, 16'hFFFC); opa32 = 32'h5555; opb32 = 32'h100; #1;
    check("t7 ready32", ready32, 1);
    @(negedge clk); inst = op_r(INTA, 7'h7f); opa32 = 32'd1; opb32 = 32'd2; #1;
    check("t7 done32 early", done32, 0);
    @(negedge clk); start32 = 1'b0; inst = '0; #1;
    check("t7 done32", done32, 1);
    check("t7 lda32", result32, 32'h0000_00FC);
    @(negedge clk); #1;
    check("t7 beef32", result32, 32'hDEAD_BEEF);
`ifdef FU_ALU_PIPE_SQUASH_CNT_EN
    check("t7 squash_cnt32", squash_cnt32, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
